ifmap_skew_feeder: RTL and testbench
====================================

# ifmap_skew_feeder

Downstream neighbour of the ifmap read address generator. Takes the word the input double buffer returns for each generated read address and feeds it to the systolic array's rows with a diagonal skew: lane r is delayed r extra cycles. It also counts reads per tile and flags the cycle in which the tile's last element leaves the bottom row.

## Interface
- IFMAP_WIDTH, 16, bits per ifmap element
- ARRAY_HEIGHT, 4, systolic array rows; number of lanes per buffer word
- COUNT_WIDTH, 16, width of the per-tile read counter and of config_data
- clk  in  1  single clock; all state changes on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- ren_i  in  1  same signal as adr_en to the read address generator; a buffer read is issued this cycle
- rdata_i  in  IFMAP_WIDTH*ARRAY_HEIGHT  buffer read data, valid the cycle after ren_i; lane r = bits [r*IFMAP_WIDTH +: IFMAP_WIDTH]
- config_en  in  1  load tile read count
- config_data  in  COUNT_WIDTH  reads per tile (OX0*OY0*FX*FY*IC1)
- ifmap_o  out  IFMAP_WIDTH*ARRAY_HEIGHT  skewed lanes to array rows, same lane packing
- ifmap_valid_o  out  ARRAY_HEIGHT  per-row valid
- tile_done_o  out  1  one-cycle pulse, see Timing
- busy_o  out  1  any element in flight

## Operation
- Stage A: ren_d register latches ren_i; it marks rdata_i as valid in the next cycle.
- Stage B: when ren_d=1, lane r of rdata_i enters a delay line of depth r+1 (capture register plus r skew registers). A valid bit travels with each lane.
- Counter:
  - config_en=1: tile_reads <= config_data, cnt <= 0.
  - Otherwise, ren_i=1 and cnt+1==tile_reads: cnt <= 0, and this read is tagged last.
  - Otherwise, ren_i=1: cnt <= cnt+1.
  - The last tag rides with the lane ARRAY_HEIGHT-1 valid bit.
- Simultaneous config_en and ren_i: config wins. The read's data still flows through the skew lines but is not counted and is never tagged last.
- tile_reads==0: the counter counts freely (wraps at 2^COUNT_WIDTH); tile_done_o never fires.
- Back-to-back tiles need no gap: cnt wraps to 0 on the last read, and the next read begins the next tile.
- busy_o = ren_d OR any valid bit in any delay line.
- The block has no back-pressure; the array always accepts data.

## Timing
- Reset (async assert, sync deassert from the system): every output = 0. All delay registers, valid bits, cnt, tile_reads and ren_d are cleared.
- Asserting reset mid-operation drops all in-flight data; no tile_done_o is produced for a partial tile.
- ren_i=1 in cycle t: rdata_i sampled at end of t+1. Row r data and ifmap_valid_o[r] are visible in cycle t+2+r.
- Per-lane throughput: one element per cycle. A gap in ren_i produces the same gap, shifted, on every row.
- tile_done_o = 1 exactly in cycle t_last+1+ARRAY_HEIGHT, where t_last is the cycle of the tagged read. This coincides with ifmap_valid_o[ARRAY_HEIGHT-1] for that element.
- busy_o drops in the first cycle after the final element's row ARRAY_HEIGHT-1 valid cycle.
- config_en takes effect at the next edge; a new count applies to reads from the following cycle onward.

## Configuration
- IFMAP_SKEW_ZERO_GATE_EN defined: each ifmap_o lane is forced to 0 in any cycle its valid bit is 0. Invalid data entering the array then contributes nothing to the MACs.
- Not defined: lanes output whatever the delay registers hold (stale data), saving the gating muxes. ifmap_valid_o behaviour is identical in both builds.

## Structure
- Shared package ifmap_pkg:
  - localparam IFMAP_SKEW_LAT = 2 (ren to row 0).
  - function skew_latency(row) returning 2+row.
  - typedef for the COUNT_WIDTH counter.
- Sub-module skew_delay_line:
  - parameters DEPTH, WIDTH.
  - ports: clk, rst_n, in_valid, in_data, out_valid, out_data.
  - Instantiated once per lane with DEPTH=r+1 via generate.
- Counter, last-tag and busy logic stay in the top.

## Test plan
- Reset: rst_n=0 mid-stream with lanes valid -> all outputs 0 immediately (async), busy_o=0. After release, no tile_done_o appears.
- Single read: ren_i=1 in cycle 10, rdata_i={16'h4,16'h3,16'h2,16'h1} in cycle 11 -> row0=1 @12, row1=2 @13, row2=3 @14, row3=4 @15. Each valid bit is high for exactly one cycle.
- Tile done: config_data=6, then 6 consecutive reads starting cycle 20 -> tile_done_o only in cycle 30, together with ifmap_valid_o[3]. busy_o falls in cycle 31.
- Back-to-back tiles with gaps: tile_reads=3, ren pattern 1,1,0,1,1,1,1 -> tile_done_o for reads #3 and #6 only. The valid pattern on each row is the input pattern shifted by 2+r.
- Config collision: config_en=1 with ren_i=1, config_data=2, then 2 more reads -> the collided read's data appears on the rows but is uncounted. tile_done_o fires for the 2nd subsequent read.
- Zero gate: build with IFMAP_SKEW_ZERO_GATE_EN, hold rdata_i=16'hFFFF on all lanes with ren_i=0 -> ifmap_o=0 always. The build without the macro shows the stale value while valid=0.

Source files
------------

// File: rtl/ifmap_pkg.sv
// Shared constants and helpers for the ifmap skew feeder.
package ifmap_pkg;

  localparam int unsigned IFMAP_SKEW_LAT    = 2;
  localparam int unsigned IFMAP_COUNT_WIDTH = 16;

  typedef logic [IFMAP_COUNT_WIDTH-1:0] ifmap_cnt_t;

  // Cycles from ren_i to data appearing on the given array row.
  function automatic int unsigned skew_latency(input int unsigned row);
    return IFMAP_SKEW_LAT + row;
  endfunction

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-depth delay line carrying one lane element plus its valid bit.
module skew_delay_line
  import ifmap_pkg::*;
#(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic [DEPTH-1:0] valid_q;
  logic [WIDTH-1:0] data_q [DEPTH];

  // Data registers only load behind a valid bit, so idle stages hold their last element.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
    end else begin
      valid_q[0] <= in_valid;
      if (in_valid) data_q[0] <= in_data;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        if (valid_q[i-1]) data_q[i] <= data_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];

endmodule

// File: rtl/ifmap_skew_feeder.sv
// Skews buffer read words onto systolic array rows and flags the end of each tile.
// Optional macro IFMAP_SKEW_ZERO_GATE_EN forces invalid lanes to zero.
module ifmap_skew_feeder
  import ifmap_pkg::*;
#(
  parameter int unsigned IFMAP_WIDTH  = 16,
  parameter int unsigned ARRAY_HEIGHT = 4,
  parameter int unsigned COUNT_WIDTH  = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            ren_i,
  input  logic [IFMAP_WIDTH*ARRAY_HEIGHT-1:0] rdata_i,
  input  logic                            config_en,
  input  logic [COUNT_WIDTH-1:0]          config_data,
  output logic [IFMAP_WIDTH*ARRAY_HEIGHT-1:0] ifmap_o,
  output logic [ARRAY_HEIGHT-1:0]         ifmap_valid_o,
  output logic                            tile_done_o,
  output logic                            busy_o
);

  logic                   ren_q;
  logic                   last_q, last_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d, cnt_inc;
  logic [COUNT_WIDTH-1:0] tile_reads_q, tile_reads_d;

  logic [ARRAY_HEIGHT-1:0] lane_valid;
  logic [IFMAP_WIDTH-1:0]  lane_data [ARRAY_HEIGHT];
  logic                    tag_valid;
  logic                    tag_data;

  assign cnt_inc = cnt_q + COUNT_WIDTH'(1);

  // A zero tile count disables tagging; the counter then wraps freely.
  always_comb begin
    cnt_d        = cnt_q;
    tile_reads_d = tile_reads_q;
    last_d       = 1'b0;
    if (config_en) begin
      tile_reads_d = config_data;
      cnt_d        = '0;
    end else if (ren_i) begin
      if ((tile_reads_q != '0) && (cnt_inc == tile_reads_q)) begin
        cnt_d  = '0;
        last_d = 1'b1;
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ren_q        <= 1'b0;
      last_q       <= 1'b0;
      cnt_q        <= '0;
      tile_reads_q <= '0;
    end else begin
      ren_q        <= ren_i;
      last_q       <= last_d;
      cnt_q        <= cnt_d;
      tile_reads_q <= tile_reads_d;
    end
  end

  for (genvar r = 0; r < ARRAY_HEIGHT; r++) begin : g_lane
    skew_delay_line #(
      .DEPTH(skew_latency(r) - IFMAP_SKEW_LAT + 1),
      .WIDTH(IFMAP_WIDTH)
    ) u_line (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (ren_q),
      .in_data  (rdata_i[r*IFMAP_WIDTH +: IFMAP_WIDTH]),
      .out_valid(lane_valid[r]),
      .out_data (lane_data[r])
    );
`ifdef IFMAP_SKEW_ZERO_GATE_EN
    assign ifmap_o[r*IFMAP_WIDTH +: IFMAP_WIDTH] = lane_valid[r] ? lane_data[r] : '0;
`else
    assign ifmap_o[r*IFMAP_WIDTH +: IFMAP_WIDTH] = lane_data[r];
`endif
  end

  // Last tag follows the bottom-row timing so tile_done lines up with its valid.
  skew_delay_line #(
    .DEPTH(ARRAY_HEIGHT),
    .WIDTH(1)
  ) u_tag (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (ren_q),
    .in_data  (last_q),
    .out_valid(tag_valid),
    .out_data (tag_data)
  );

  assign ifmap_valid_o = lane_valid;
  assign tile_done_o   = tag_valid & tag_data;
  // Every in-flight element is visible on exactly one row, so the row valids cover all lines.
  assign busy_o        = ren_q | (|lane_valid);

endmodule

// File: tb/tb_ifmap_skew_feeder.sv
// Randomized bench for ifmap_skew_feeder against a cycle-indexed expectation model.
module tb_ifmap_skew_feeder;
  import ifmap_pkg::*;

  localparam int W    = 16;
  localparam int H    = 4;
  localparam int CW   = 16;
  localparam int MAXC = 4096;

  logic              clk;
  logic              rst_n;
  logic              ren_i;
  logic [W*H-1:0]    rdata_i;
  logic              config_en;
  logic [CW-1:0]     config_data;
  logic [W*H-1:0]    ifmap_o;
  logic [H-1:0]      ifmap_valid_o;
  logic              tile_done_o;
  logic              busy_o;

  ifmap_skew_feeder #(
    .IFMAP_WIDTH (W),
    .ARRAY_HEIGHT(H),
    .COUNT_WIDTH (CW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ren_i        (ren_i),
    .rdata_i      (rdata_i),
    .config_en    (config_en),
    .config_data  (config_data),
    .ifmap_o      (ifmap_o),
    .ifmap_valid_o(ifmap_valid_o),
    .tile_done_o  (tile_done_o),
    .busy_o       (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;
  int cyc;
  int done_seen;

  // Expectations indexed by absolute cycle number since the last reset.
  bit         exp_v    [MAXC][H];
  logic [W-1:0] exp_d  [MAXC][H];
  bit         exp_done [MAXC];
  bit         ren_hist [MAXC];
  int         m_tile;
  int         m_cnt;
  bit         prev_ren;
  logic [W*H-1:0] pending;
  logic [W*H-1:0] idle_data;

  task automatic clear_model();
    for (int c = 0; c < MAXC; c++) begin
      exp_done[c] = 1'b0;
      ren_hist[c] = 1'b0;
      for (int r = 0; r < H; r++) begin
        exp_v[c][r] = 1'b0;
        exp_d[c][r] = '0;
      end
    end
    m_tile   = 0;
    m_cnt    = 0;
    prev_ren = 1'b0;
  endtask

  // Drives one cycle, updates the model, checks outputs at the falling edge.
  task automatic cycle_step(input bit ren, input logic [W*H-1:0] data, input bit cfg,
                            input int cfg_data);
    bit exp_busy;
    ren_i       = ren;
    config_en   = cfg;
    config_data = CW'(cfg_data);
    rdata_i     = prev_ren ? pending : idle_data;
    if (ren) begin
      pending = data;
      for (int r = 0; r < H; r++) begin
        exp_v[cyc+2+r][r] = 1'b1;
        exp_d[cyc+2+r][r] = data[r*W +: W];
      end
    end
    ren_hist[cyc] = ren;
    if (cfg) begin
      m_tile = cfg_data;
      m_cnt  = 0;
    end else if (ren) begin
      if (m_tile != 0 && ((m_cnt + 1) % 65536) == m_tile) begin
        exp_done[cyc+1+H] = 1'b1;
        m_cnt = 0;
      end else begin
        m_cnt = (m_cnt + 1) % 65536;
      end
    end
    prev_ren = ren;

    @(negedge clk);
    exp_busy = (cyc > 0) && ren_hist[cyc-1];
    for (int r = 0; r < H; r++) begin
      exp_busy = exp_busy | exp_v[cyc][r];
      checks++;
      if (ifmap_valid_o[r] !== exp_v[cyc][r]) begin
        failures++;
        $display("FAIL valid row=%0d cyc=%0d got=%0b exp=%0b", r, cyc, ifmap_valid_o[r],
                 exp_v[cyc][r]);
      end
      if (exp_v[cyc][r]) begin
        checks++;
        if (ifmap_o[r*W +: W] !== exp_d[cyc][r]) begin
          failures++;
          $display("FAIL data row=%0d cyc=%0d got=%h exp=%h", r, cyc, ifmap_o[r*W +: W],
                   exp_d[cyc][r]);
        end
      end
`ifdef IFMAP_SKEW_ZERO_GATE_EN
      else begin
        checks++;
        if (ifmap_o[r*W +: W] !== '0) begin
          failures++;
          $display("FAIL gate row=%0d cyc=%0d got=%h exp=0", r, cyc, ifmap_o[r*W +: W]);
        end
      end
`endif
    end
    checks++;
    if (tile_done_o !== exp_done[cyc]) begin
      failures++;
      $display("FAIL tile_done cyc=%0d got=%0b exp=%0b", cyc, tile_done_o, exp_done[cyc]);
    end
    if (tile_done_o === 1'b1) done_seen++;
    checks++;
    if (busy_o !== exp_busy) begin
      failures++;
      $display("FAIL busy cyc=%0d got=%0b exp=%0b", cyc, busy_o, exp_busy);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle_step(1'b0, '0, 1'b0, 0);
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if (ifmap_o !== '0 || ifmap_valid_o !== '0 || tile_done_o !== 1'b0 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL %s got ifmap=%h valid=%b done=%b busy=%b exp all zero", tag, ifmap_o,
               ifmap_valid_o, tile_done_o, busy_o);
    end
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    ren_i       = 1'b0;
    config_en   = 1'b0;
    config_data = '0;
    rdata_i     = '0;
    idle_data   = {$urandom, $urandom};
    clear_model();
    #3;
    check_all_zero("reset_state");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc = 0;
    idle(3);
  endtask

  task automatic test_single_read();
    done_seen = 0;
    idle(2);
    cycle_step(1'b1, {16'h0004, 16'h0003, 16'h0002, 16'h0001}, 1'b0, 0);
    idle(8);
    checks++;
    if (done_seen != 0) begin
      failures++;
      $display("FAIL single_done_count got=%0d exp=0", done_seen);
    end
  endtask

  task automatic test_tile_done();
    done_seen = 0;
    cycle_step(1'b0, '0, 1'b1, 6);
    for (int i = 0; i < 6; i++) cycle_step(1'b1, {$urandom, $urandom}, 1'b0, 0);
    idle(10);
    checks++;
    if (done_seen != 1) begin
      failures++;
      $display("FAIL tile_done_count got=%0d exp=1", done_seen);
    end
  endtask

  task automatic test_back_to_back();
    bit pat [7] = '{1, 1, 0, 1, 1, 1, 1};
    done_seen = 0;
    cycle_step(1'b0, '0, 1'b1, 3);
    for (int i = 0; i < 7; i++) cycle_step(pat[i], {$urandom, $urandom}, 1'b0, 0);
    idle(10);
    checks++;
    if (done_seen != 2) begin
      failures++;
      $display("FAIL b2b_done_count got=%0d exp=2", done_seen);
    end
  endtask

  task automatic test_collision();
    done_seen = 0;
    cycle_step(1'b1, {$urandom, $urandom}, 1'b1, 2);
    cycle_step(1'b1, {$urandom, $urandom}, 1'b0, 0);
    cycle_step(1'b1, {$urandom, $urandom}, 1'b0, 0);
    idle(10);
    checks++;
    if (done_seen != 1) begin
      failures++;
      $display("FAIL collision_done_count got=%0d exp=1", done_seen);
    end
  endtask

  task automatic test_zero_gate();
    logic [W*H-1:0] word;
    logic [W-1:0]   exp_lane;
    word      = {16'h0044, 16'h0033, 16'h0022, 16'h0011};
    idle_data = '1;
    cycle_step(1'b1, word, 1'b0, 0);
    idle(9);
    for (int r = 0; r < H; r++) begin
`ifdef IFMAP_SKEW_ZERO_GATE_EN
      exp_lane = '0;
`else
      exp_lane = word[r*W +: W];
`endif
      checks++;
      if (ifmap_o[r*W +: W] !== exp_lane) begin
        failures++;
        $display("FAIL idle_lane row=%0d got=%h exp=%h", r, ifmap_o[r*W +: W], exp_lane);
      end
    end
    idle_data = {$urandom, $urandom};
  endtask

  task automatic test_random();
    bit ren;
    bit cfg;
    ifmap_cnt_t tile;
    cycle_step(1'b0, '0, 1'b1, $urandom_range(1, 7));
    for (int i = 0; i < 400; i++) begin
      cfg  = ($urandom_range(0, 39) == 0);
      ren  = ($urandom_range(0, 9) < 7);
      tile = ifmap_cnt_t'($urandom_range(0, 7));
      cycle_step(ren, {$urandom, $urandom}, cfg, int'(tile));
    end
    idle(10);
  endtask

  task automatic test_reset_midstream();
    done_seen = 0;
    cycle_step(1'b0, '0, 1'b1, 4);
    for (int i = 0; i < 3; i++) cycle_step(1'b1, {$urandom, $urandom}, 1'b0, 0);
    // Lanes are now carrying data; drop reset between edges.
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("reset_midstream");
    ren_i     = 1'b0;
    config_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_all_zero("reset_held");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    clear_model();
    cyc = 0;
    idle(12);
    checks++;
    if (done_seen != 0) begin
      failures++;
      $display("FAIL reset_partial_done got=%0d exp=0", done_seen);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    cyc      = 0;
    test_reset();
    test_single_read();
    test_tile_done();
    test_back_to_back();
    test_collision();
    test_zero_gate();
    test_random();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
